// File: rtl/tdc_frame_buf.sv
// tdc_frame_buf: captures a TDC hit burst, applies a latched signed offset, serves words to SPI.
// Optional clamping of calibrated words: define TDC_FRAME_BUF_SAT_EN.  Rev 1.0
`default_nettype none

module tdc_frame_buf #(
  parameter int DW    = 19,
  parameter int CW    = 20,
  parameter int DEPTH = 5,
  localparam int NW   = $clog2(DEPTH + 1),
  localparam int OW   = DW + 1 + 2 * NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tdc_ovalid,
  input  logic [DW-1:0] tdc_odata,
  input  logic [CW-1:0] tdc_calib,
  output logic          tdc_oready,
  input  logic          spi_odstart,
  output logic [OW-1:0] out,
  output logic          int_raw,
  output logic          int_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    CALIB = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic [NW-1:0]   cnt, ci, rd;
  logic            ovf;
  logic [CW-1:0]   cal_r;
  logic [CW:0]     sum;
  logic [DW-1:0]   cal_word;
  logic            ci_last, rd_last;

  assign ci_last = (ci == cnt - NW'(1));
  assign rd_last = (rd == cnt - NW'(1));

  // Offset is sign-extended; the raw hit is always treated as non-negative.
  assign sum = {{(CW + 1 - DW){1'b0}}, mem[ci[AW-1:0]]} + {cal_r[CW-1], cal_r};

`ifdef TDC_FRAME_BUF_SAT_EN
  always_comb begin
    cal_word = sum[DW-1:0];
    if (sum[CW])
      cal_word = '0;
    else if (|sum[CW-1:DW])
      cal_word = '1;
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[CW:DW];
  assign cal_word      = sum[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tdc_oready = 1'b0;
    out        = '0;
    int_raw    = 1'b0;
    int_ovf    = 1'b0;
    unique case (state)
      IDLE: begin
        tdc_oready = 1'b1;
        if (tdc_ovalid) state_nxt = CAPT;
      end
      CAPT: begin
        tdc_oready = 1'b1;
        if (!tdc_ovalid) state_nxt = CALIB;
      end
      CALIB: begin
        if (ci_last) state_nxt = FULL;
      end
      FULL: begin
        out     = {mem[rd[AW-1:0]], ovf, cnt, rd + NW'(1)};
        int_raw = 1'b1;
        int_ovf = ovf;
        if (spi_odstart && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      ci    <= '0;
      rd    <= '0;
      ovf   <= 1'b0;
      cal_r <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tdc_ovalid) begin
            mem[0] <= tdc_odata;
            cnt    <= NW'(1);
            ovf    <= 1'b0;
            cal_r  <= tdc_calib;
          end
        end
        CAPT: begin
          if (tdc_ovalid) begin
            if (cnt < NW'(DEPTH)) begin
              mem[cnt[AW-1:0]] <= tdc_odata;
              cnt              <= cnt + NW'(1);
            end else begin
              ovf <= 1'b1;
            end
          end else begin
            ci <= '0;
          end
        end
        CALIB: begin
          mem[ci[AW-1:0]] <= cal_word;
          ci              <= ci + NW'(1);
          if (ci_last) rd <= '0;
        end
        FULL: begin
          if (spi_odstart && !rd_last) rd <= rd + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_frame_buf.sv
// Directed self-checking bench for tdc_frame_buf at default parameters.
`default_nettype none

module tb_tdc_frame_buf;

  localparam int DW = 19;
  localparam int CW = 20;
  localparam int OW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          tdc_ovalid;
  logic [DW-1:0] tdc_odata;
  logic [CW-1:0] tdc_calib;
  logic          tdc_oready;
  logic          spi_odstart;
  logic [OW-1:0] out;
  logic          int_raw;
  logic          int_ovf;

  int total = 0;
  int bad   = 0;

  tdc_frame_buf dut (
    .clk         (clk),
    .rst         (rst),
    .tdc_ovalid  (tdc_ovalid),
    .tdc_odata   (tdc_odata),
    .tdc_calib   (tdc_calib),
    .tdc_oready  (tdc_oready),
    .spi_odstart (spi_odstart),
    .out         (out),
    .int_raw     (int_raw),
    .int_ovf     (int_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] word(input int d, input bit o, input int n, input int t);
    logic [31:0] dv, nv, tv;
    dv = d; nv = n; tv = t;
    return {dv[DW-1:0], o, nv[2:0], tv[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input int c);
    tdc_ovalid = 1'b1;
    tdc_odata  = DW'(d);
    tdc_calib  = CW'(c);
    tick();
  endtask

  task automatic end_frame();
    tdc_ovalid = 1'b0;
    tick();
  endtask

  task automatic wait_full(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (int_raw) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse();
    spi_odstart = 1'b1;
    tick();
    spi_odstart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tdc_ovalid = 1'b0; tdc_odata = '0; tdc_calib = '0; spi_odstart = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({tdc_oready, int_raw, int_ovf} !== 3'b100 || out !== '0) begin
      bad++;
      $display("FAIL reset: got oready/raw/ovf=%b out=%h want 100 out=0",
               {tdc_oready, int_raw, int_ovf}, out);
    end
  endtask

  task automatic test_three_beat();
    beat(100, 10); beat(200, 10); beat(300, 10);
    end_frame();
    tick(); tick();
    total++;
    if (int_raw !== 1'b0) begin
      bad++; $display("FAIL three_early: int_raw got %b want 0 at E+3", int_raw);
    end
    tick();
    total++;
    if (int_raw !== 1'b1 || out !== word(110, 0, 3, 1)) begin
      bad++; $display("FAIL three_w1: raw=%b out=%h want 1 %h", int_raw, out, word(110, 0, 3, 1));
    end
    pulse();
    total++;
    if (out !== word(210, 0, 3, 2)) begin
      bad++; $display("FAIL three_w2: got %h want %h", out, word(210, 0, 3, 2));
    end
    pulse();
    total++;
    if (out !== word(310, 0, 3, 3)) begin
      bad++; $display("FAIL three_w3: got %h want %h", out, word(310, 0, 3, 3));
    end
    pulse();
    total++;
    if (int_raw !== 1'b0 || tdc_oready !== 1'b1 || out !== '0) begin
      bad++; $display("FAIL three_done: raw=%b oready=%b out=%h want 0 1 0", int_raw, tdc_oready, out);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 1; i <= 7; i++) beat(i, 0);
    end_frame();
    wait_full(ok);
    total++;
    if (!ok || int_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_flag: full=%b int_ovf=%b want 1 1", ok, int_ovf);
    end
    spi_odstart = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      total++;
      if (out !== word(i, 1, 5, i)) begin
        bad++; $display("FAIL ovf_word%0d: got %h want %h", i, out, word(i, 1, 5, i));
      end
      tick();
    end
    spi_odstart = 1'b0;
    total++;
    if (int_raw !== 1'b0 || int_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_done: raw=%b ovf=%b want 0 0 after 5 words", int_raw, int_ovf);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [OW-1:0] e1, e2;
`ifdef TDC_FRAME_BUF_SAT_EN
    e1 = word(0, 0, 1, 1);
    e2 = word(32'h7FFFF, 0, 1, 1);
`else
    e1 = word(32'h7FFF1, 0, 1, 1);
    e2 = word(0, 0, 1, 1);
`endif
    beat(5, -20);
    end_frame();
    wait_full(ok);
    total++;
    if (!ok || out !== e1) begin
      bad++; $display("FAIL sat_neg: full=%b got %h want %h", ok, out, e1);
    end
    pulse();
    beat(32'h7FFFF, 1);
    end_frame();
    wait_full(ok);
    total++;
    if (!ok || out !== e2) begin
      bad++; $display("FAIL sat_pos: full=%b got %h want %h", ok, out, e2);
    end
    pulse();
  endtask

  task automatic test_backpressure();
    bit ok;
    beat(7, 0); beat(8, 0);
    end_frame();
    wait_full(ok);
    beat(999, 0); beat(999, 0);
    total++;
    if (!ok || tdc_oready !== 1'b0 || out !== word(7, 0, 2, 1)) begin
      bad++; $display("FAIL bp_hold: full=%b oready=%b out=%h want 1 0 %h", ok, tdc_oready, out, word(7, 0, 2, 1));
    end
    tdc_ovalid = 1'b0;
    pulse();
    total++;
    if (out !== word(8, 0, 2, 2)) begin
      bad++; $display("FAIL bp_w2: got %h want %h", out, word(8, 0, 2, 2));
    end
    pulse();
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (int_raw !== 1'b0 || tdc_oready !== 1'b1 || out !== '0) begin
      bad++; $display("FAIL bp_noframe: raw=%b oready=%b out=%h want 0 1 0", int_raw, tdc_oready, out);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    beat(11, 0); beat(12, 0); beat(13, 0);
    end_frame();
    wait_full(ok);
    pulse();
    rst = 1'b1;
    tick();
    total++;
    if (!ok || out !== '0 || int_raw !== 1'b0 || tdc_oready !== 1'b1) begin
      bad++; $display("FAIL rst_mid: full=%b out=%h raw=%b oready=%b want 1 0 0 1", ok, out, int_raw, tdc_oready);
    end
    rst = 1'b0;
    beat(42, 0);
    end_frame();
    wait_full(ok);
    total++;
    if (!ok || out !== word(42, 0, 1, 1)) begin
      bad++; $display("FAIL rst_newframe: full=%b got %h want %h", ok, out, word(42, 0, 1, 1));
    end
    pulse();
  endtask

  task automatic test_calib_latch();
    bit ok;
    beat(50, 5);
    tdc_calib  = CW'(100);
    end_frame();
    wait_full(ok);
    total++;
    if (!ok || out !== word(55, 0, 1, 1)) begin
      bad++; $display("FAIL calib_latch: full=%b got %h want %h", ok, out, word(55, 0, 1, 1));
    end
    pulse();
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_overflow();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_calib_latch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
